// File: rtl/crc_arbiter_if.sv
// Handshake bundle between the two CRC requesters, the arbiter and the shared CRC-15 engine.
interface crc_arbiter_if;
  logic [1:0]  req;
  logic [23:0] din0;
  logic [23:0] din1;
  logic [15:0] size0;
  logic [15:0] size1;
  logic [1:0]  gnt;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [14:0] rsp_crc;
  logic        rsp_err;
  logic        eng_valid;
  logic [23:0] eng_din;
  logic [15:0] eng_size;
  logic        eng_done;
  logic [14:0] eng_checksum;
  logic        busy;

  modport slave (
    input  req, din0, din1, size0, size1, rsp_ready, eng_done, eng_checksum,
    output gnt, rsp_valid, rsp_crc, rsp_err, eng_valid, eng_din, eng_size, busy
  );

  modport master (
    output req, din0, din1, size0, size1, rsp_ready, eng_done, eng_checksum,
    input  gnt, rsp_valid, rsp_crc, rsp_err, eng_valid, eng_din, eng_size, busy
  );
endinterface

// File: rtl/crc_arbiter.sv
// Two-requester arbiter in front of a shared CRC-15 engine: one transaction in
// flight, round-robin on contention, size check and engine timeout.
module crc_arbiter #(
  parameter int TIMEOUT = 100
) (
  input  logic           clk,
  input  logic           rst,
  crc_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_e;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          owner_q, owner_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [23:0]   din_q, din_d;
  logic [15:0]   size_q, size_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [14:0]   crc_q, crc_d;
  logic          err_q, err_d;

  logic          winner;
  logic [23:0]   win_din;
  logic [15:0]   win_size;
  logic          size_ok;

  // A lone request wins outright; contention is settled by the priority pointer.
  assign winner   = (bus.req == 2'b11) ? prio_q : bus.req[1];
  assign win_din  = winner ? bus.din1  : bus.din0;
  assign win_size = winner ? bus.size1 : bus.size0;
  assign size_ok  = (win_size == 16'd2) || (win_size == 16'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      timer_q <= '0;
      din_q   <= '0;
      size_q  <= '0;
      gnt_q   <= '0;
      crc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      din_q   <= din_d;
      size_q  <= size_d;
      gnt_q   <= gnt_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    timer_d = timer_q;
    din_d   = din_q;
    size_d  = size_q;
    gnt_d   = '0;
    crc_d   = crc_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          owner_d = winner;
          din_d   = win_din;
          size_d  = win_size;
          gnt_d   = winner ? 2'b10 : 2'b01;
          if (size_ok) begin
            state_d = LAUNCH;
          end else begin
            crc_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        // Completion takes precedence over a timeout landing on the same cycle.
        if (bus.eng_done) begin
          crc_d   = bus.eng_checksum;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          crc_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign bus.gnt[gi]       = gnt_q[gi];
      assign bus.rsp_valid[gi] = (state_q == RESP) && (owner_q == 1'(gi));
    end
  endgenerate

  assign bus.rsp_crc   = crc_q;
  assign bus.rsp_err   = err_q;
  assign bus.eng_valid = (state_q == LAUNCH);
  assign bus.eng_din   = ((state_q == LAUNCH) || (state_q == WAIT)) ? din_q  : '0;
  assign bus.eng_size  = ((state_q == LAUNCH) || (state_q == WAIT)) ? size_q : '0;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_crc_arbiter.sv
// Directed plus randomized transactions against a transaction-level model of
// arbitration, size check, engine latency and timeout.
module tb_crc_arbiter;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic prio_m = 1'b0;

  crc_arbiter_if bus();

  crc_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},       32'(bus.gnt),       32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_crc"},   32'(bus.rsp_crc),   32'd0);
    check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
    check({tag, "_eng_valid"}, 32'(bus.eng_valid), 32'd0);
    check({tag, "_eng_din"},   32'(bus.eng_din),   32'd0);
    check({tag, "_eng_size"},  32'(bus.eng_size),  32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.eng_done = 1'b0;
    bus.eng_checksum = '0;
    step();
    step();
    rst = 1'b0;
    prio_m = 1'b0;
  endtask

  // One full transaction starting with the DUT idle. lat = WAIT cycle on which
  // the engine reports done (beyond TIMEOUT means it never does).
  task automatic txn(input logic [1:0] rq, input logic [23:0] d0, input logic [23:0] d1,
                     input logic [15:0] s0, input logic [15:0] s1, input int lat,
                     input logic [14:0] chk, input int rwait);
    logic        w;
    logic [1:0]  wm;
    logic [23:0] dw;
    logic [15:0] sw;
    logic        ok;
    int          n;
    logic [14:0] exp_crc;
    logic        exp_err;

    bus.req = rq; bus.din0 = d0; bus.din1 = d1; bus.size0 = s0; bus.size1 = s1;
    w  = (rq == 2'b11) ? prio_m : (rq == 2'b10);
    wm = w ? 2'b10 : 2'b01;
    dw = w ? d1 : d0;
    sw = w ? s1 : s0;
    ok = (sw == 16'd2) || (sw == 16'd3);
    step();
    check("gnt", 32'(bus.gnt), 32'(wm));
    check("busy_cap", 32'(bus.busy), 32'd1);
    if (ok) begin
      check("eng_valid_launch", 32'(bus.eng_valid), 32'd1);
      check("eng_din_launch", 32'(bus.eng_din), 32'(dw));
      check("eng_size_launch", 32'(bus.eng_size), 32'(sw));
      n = (lat <= TIMEOUT) ? lat : TIMEOUT;
      step();
      check("gnt_drop", 32'(bus.gnt), 32'd0);
      for (int k = 1; k <= n; k++) begin
        check("eng_valid_wait", 32'(bus.eng_valid), 32'd0);
        check("eng_din_wait", 32'(bus.eng_din), 32'(dw));
        check("eng_size_wait", 32'(bus.eng_size), 32'(sw));
        check("rsp_valid_wait", 32'(bus.rsp_valid), 32'd0);
        bus.eng_done = (k == lat);
        bus.eng_checksum = (k == lat) ? chk : 15'($urandom);
        step();
      end
      bus.eng_done = 1'b0;
      exp_crc = (lat <= TIMEOUT) ? chk : 15'd0;
      exp_err = (lat > TIMEOUT);
    end else begin
      check("eng_valid_szerr", 32'(bus.eng_valid), 32'd0);
      exp_crc = 15'd0;
      exp_err = 1'b1;
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'(wm));
    check("rsp_crc", 32'(bus.rsp_crc), 32'(exp_crc));
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    for (int r = 0; r < rwait; r++) begin
      bus.rsp_ready = ~wm;
      bus.eng_done = 1'($urandom);
      bus.eng_checksum = 15'($urandom);
      step();
      check("rsp_valid_hold", 32'(bus.rsp_valid), 32'(wm));
      check("rsp_crc_hold", 32'(bus.rsp_crc), 32'(exp_crc));
      check("rsp_err_hold", 32'(bus.rsp_err), 32'(exp_err));
      check("busy_hold", 32'(bus.busy), 32'd1);
      check("eng_valid_hold", 32'(bus.eng_valid), 32'd0);
    end
    bus.rsp_ready = wm;
    bus.eng_done = 1'b0;
    step();
    bus.rsp_ready = 2'b00;
    check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("eng_din_idle", 32'(bus.eng_din), 32'd0);
    prio_m = ~w;
    $display("txn req=%b owner=%0d size=%0d lat=%0d crc=%h err=%0d", rq, w, sw, lat, exp_crc, exp_err);
  endtask

  initial begin
    bus.din0 = '0; bus.din1 = '0; bus.size0 = '0; bus.size1 = '0;
    do_reset();
    check_all_zero("reset");

    // Single TX-builder request, engine answers on its 30th WAIT cycle.
    txn(2'b01, 24'h00A5C3, 24'h0, 16'd2, 16'd0, 30, 15'h1234, 0);
    bus.req = 2'b00;

    // Bad size from RX checker: immediate error response, engine untouched.
    txn(2'b10, 24'h0, 24'h123456, 16'd0, 16'd5, 1, 15'h0, 0);
    bus.req = 2'b00;

    // Contention alternates: 0, 1, 0 with req held at 11.
    do_reset();
    txn(2'b11, 24'h111111, 24'h222222, 16'd3, 16'd2, 5, 15'h0AAA, 0);
    txn(2'b11, 24'h111111, 24'h222222, 16'd3, 16'd2, 7, 15'h1555, 1);
    txn(2'b11, 24'h111111, 24'h222222, 16'd3, 16'd2, 3, 15'h7FFF, 0);
    bus.req = 2'b00;
    step();
    check("idle_no_req_busy", 32'(bus.busy), 32'd0);
    check("idle_no_req_gnt", 32'(bus.gnt), 32'd0);

    // Timeout boundary: never done, then done on the last allowed cycle.
    txn(2'b01, 24'hABCDEF, 24'h0, 16'd3, 16'd0, 1000, 15'h0, 0);
    txn(2'b01, 24'hABCDEF, 24'h0, 16'd3, 16'd0, TIMEOUT, 15'h2468, 0);
    txn(2'b10, 24'h0, 24'h0F0F0F, 16'd0, 16'd2, TIMEOUT - 1, 15'h1357, 0);

    // Long backpressure with non-owner ready asserted.
    txn(2'b10, 24'h0, 24'h765432, 16'd0, 16'd3, 12, 15'h3C3C, 10);
    bus.req = 2'b00;

    // Reset in the middle of WAIT, then a late completion.
    bus.req = 2'b01; bus.din0 = 24'h5A5A5A; bus.size0 = 16'd3;
    step();
    step();
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    bus.req = 2'b00;
    step();
    rst = 1'b0;
    prio_m = 1'b0;
    check_all_zero("midrst");
    bus.eng_done = 1'b1;
    bus.eng_checksum = 15'h4321;
    step();
    bus.eng_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("late_done_busy", 32'(bus.busy), 32'd0);
      step();
    end
    $display("txn reset-abort late_done ignored");

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  rq;
      logic [15:0] s0, s1;
      int          lat;
      rq = 2'(1 + $urandom_range(0, 2));
      s0 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(2 + $urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(2 + $urandom_range(0, 1));
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 3, TIMEOUT + 5)
                                        : $urandom_range(1, 20);
      txn(rq, 24'($urandom), 24'($urandom), s0, s1, lat, 15'($urandom),
          $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        bus.req = 2'b00;
        step();
        check("gap_busy", 32'(bus.busy), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crc_arbiter.md
CRC_ARBITER -- requirements
Module: crc_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 100: max cycles in WAIT before abort.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req  in  2  per-requester request (bit 0 = TX builder, bit 1 = RX checker); held until gnt.
REQ-005 din0, din1  in  24 each  requester data packet, MSB-aligned to size.
REQ-006 size0, size1  in  16 each  requester byte count.
REQ-007 gnt  out  2  one-cycle pulse: requester's din/size captured.
REQ-008 rsp_valid  out  2  result available for the owning requester.
REQ-009 rsp_ready  in  2  per-requester result acceptance.
REQ-010 rsp_crc  out  15  checksum for owner.
REQ-011 rsp_err  out  1  high with rsp_valid on size error or timeout.
REQ-012 eng_valid  out  1  one-cycle start pulse to shared CRC-15 engine.
REQ-013 eng_din  out  24, eng_size  out  16  engine operands.
REQ-014 eng_done  in  1  engine completion pulse.
REQ-015 eng_checksum  in  15  engine result, valid while eng_done high.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, LAUNCH, WAIT, RESP; one-hot or encoded at implementer's choice.
REQ-018 IDLE: if req != 0 at an edge, select winner, latch its din/size, set owner; else stay.
REQ-019 Winner: only one bit set -> that requester; both set -> requester at priority pointer prio.
REQ-020 Latched size in {2,3} -> LAUNCH; any other size -> RESP with rsp_err=1, rsp_crc=0, engine untouched.
REQ-021 gnt[owner] high for exactly the one cycle following capture (first cycle of LAUNCH or RESP).
REQ-022 LAUNCH: eng_valid=1 for one cycle; next state WAIT; timer cleared to 0.
REQ-023 eng_din/eng_size driven from latched registers, stable from LAUNCH through WAIT; 0 in IDLE.
REQ-024 WAIT: timer increments each cycle; eng_done=1 -> capture eng_checksum into rsp_crc, rsp_err=0, go RESP.
REQ-025 WAIT: timer == TIMEOUT-1 with eng_done=0 -> RESP, rsp_err=1, rsp_crc=0.
REQ-026 eng_done and timeout in same cycle: done wins, no error.
REQ-027 eng_done outside WAIT is ignored.
REQ-028 RESP: rsp_valid[owner]=1, other bit 0; rsp_crc/rsp_err held stable until rsp_ready[owner]=1.
REQ-029 RESP handshake (rsp_valid & rsp_ready on owner bit): prio <= other requester, go IDLE; rsp_valid drops next cycle.
REQ-030 rsp_ready on the non-owner bit is ignored.
REQ-031 req dropped before capture: no grant, no state change; req still high after RESP treated as new request.
REQ-032 Minimum turnaround: req in IDLE to next IDLE = 1 + 1 + engine latency + 1 + ready wait cycles.
REQ-033 Only one transaction in flight; new requests wait in IDLE arbitration.

Reset
REQ-034 rst=1 at an edge: state IDLE, prio=0, timer=0, gnt=0, rsp_valid=0, rsp_crc=0, rsp_err=0, eng_valid=0, eng_din=0, eng_size=0, busy=0.
REQ-035 Reset mid-transaction abandons it silently; no rsp_valid generated; late eng_done ignored.

Verification
REQ-036 req=01, din0=24'h00A5C3, size0=2; eng_done after 30 cycles with eng_checksum=15'h1234 -> gnt=01 one cycle, eng_valid one cycle with eng_size=2, rsp_valid=01, rsp_crc=15'h1234, rsp_err=0.
REQ-037 req=11 after reset -> requester 0 granted; after its handshake with req still 11 -> requester 1 granted; then requester 0 again.
REQ-038 req=10, size1=5 -> gnt=10, no eng_valid, rsp_valid=10, rsp_err=1, rsp_crc=0.
REQ-039 Engine never asserts eng_done, TIMEOUT=100 -> rsp_valid after exactly 100 WAIT cycles with rsp_err=1; eng_done on cycle 100 instead -> rsp_err=0.
REQ-040 rsp_ready held 0 for 10 cycles in RESP -> outputs stable, busy=1; rst pulsed during WAIT -> all outputs 0 next cycle, subsequent eng_done produces no rsp_valid.
